// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and the default datapath width.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The master issues operations; the slave is the unit itself.
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = MD_WIDTH);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_addsub.sv
// Shared adder: multiply accumulate when sub=0, divide trial subtract when
// sub=1. For subtraction, carry=1 means x >= y (no borrow).
module muldiv_addsub #(parameter int W = 33) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{W{1'b0}}, sub};
  assign sum   = full[W-1:0];
  assign carry = full[W];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO, plus MTHI/MTLO.
// Works on magnitudes for WIDTH cycles, then applies signs in FIX.
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = MD_WIDTH) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   acc_hi, acc_lo, divisor, raw_a;
  logic               is_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               done_r;

  logic               accept, op_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     as_x, as_y, as_sum, mul_step;
  logic               as_carry;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign op_signed = ~bus.op[0];
  assign mag_a     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Divide shifts the next dividend bit into the remainder before the
  // trial subtract; multiply adds the multiplicand to the upper half.
  assign as_x     = is_div ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
  assign as_y     = {1'b0, divisor};
  assign mul_step = acc_lo[0] ? as_sum : as_x;

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .x     (as_x),
    .y     (as_y),
    .sub   (is_div),
    .sum   (as_sum),
    .carry (as_carry)
  );

  always_comb begin
    product = {acc_hi, acc_lo};
    if (neg_q) product = -product;
    if (!is_div) begin
      {hi_fix, lo_fix} = product;
    end else if (div_zero) begin
      hi_fix = raw_a;
      lo_fix = '1;
    end else begin
      lo_fix = neg_q ? -acc_lo : acc_lo;
      hi_fix = neg_r ? -acc_hi : acc_hi;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept && !bus.op[2]) state_next = CALC;
      CALC:    if (bus.flush) state_next = IDLE;
               else if (count == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      divisor  <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      done_r   <= 1'b0;
    end else begin
      state  <= state_next;
      done_r <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          if (!bus.op[2]) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            divisor  <= mag_b;
            raw_a    <= bus.a;
            is_div   <= bus.op[1];
            neg_q    <= op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r    <= op_signed && bus.a[WIDTH-1];
            div_zero <= (bus.b == '0);
          end else if (bus.op == OP_MTHI) begin
            hi_r <= bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_r <= bus.a;
          end
        end
        CALC: if (!bus.flush) begin
          count <= count + CNT_W'(1);
          if (is_div) begin
            acc_hi <= as_carry ? as_sum[WIDTH-1:0] : as_x[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], as_carry};
          end else begin
            acc_hi <= mul_step[WIDTH:1];
            acc_lo <= {mul_step[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: if (!bus.flush) begin
          hi_r   <= hi_fix;
          lo_r   <= lo_fix;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: table vectors and random ops feed a scoreboard
// of expected {hi,lo}; hand sequences cover MTHI/MTLO, busy, flush and reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          check_count = 0;
  int          pass_count = 0;
  int          done_count = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mon_exp;
  vec_t        vecs[10];

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit push, input logic [63:0] exp);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) sb_q.push_back(exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              da, db;
    model = '0;
    case (op)
      OP_MULT:  begin sa = $signed(a); sb = $signed(b); model = sa * sb; end
      OP_MULTU: begin ua = a; ub = b; model = ua * ub; end
      OP_DIV: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else begin da = a; db = b; model = {32'(da % db), 32'(da / db)}; end
      end
      OP_DIVU: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
      default: model = '0;
    endcase
  endfunction

  // Issue one arithmetic op and wait, bounded, for its done pulse.
  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    int cycles = 0;
    bit seen = 1'b0;
    applyStimulus(op, a, b, 1'b1, exp);
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        bus.start = 1'b0;
        checkOutput({name, " busy"}, 64'(bus.busy), 64'd1);
      end
      if (bus.done) seen = 1'b1;
    end
    checkOutput({name, " latency"}, 64'(cycles), 64'd34);
    checkOutput({name, " busy at done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    checkOutput({name, " done pulse"}, 64'(bus.done), 64'd0);
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      done_count++;
      if (sb_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected done: hi %h lo %h with empty scoreboard", bus.hi, bus.lo);
      end else begin
        mon_exp = sb_q.pop_front();
        checkOutput("sb hi", 64'(bus.hi), 64'(mon_exp[63:32]));
        checkOutput("sb lo", 64'(bus.lo), 64'(mon_exp[31:0]));
      end
    end
  end

  initial begin
    logic [31:0] hold_hi, hold_lo, ra, rb;
    logic [2:0]  rop;
    int          done_before;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
    vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{OP_DIV,   32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6] = '{OP_DIVU,  32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF};
    vecs[7] = '{OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
    vecs[8] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9] = '{OP_MULTU, 32'h1234_5678, 32'h10,       32'h0000_0001, 32'h2345_6780};

    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    #1;
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset hi", 64'(bus.hi), 64'd0);
    checkOutput("reset lo", 64'(bus.lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo});

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      runOp($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    // MTHI then MTLO on back-to-back cycles.
    applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, '0);
    @(negedge clk);
    checkOutput("mthi hi", 64'(bus.hi), 64'hDEAD_BEEF);
    checkOutput("mthi busy", 64'(bus.busy), 64'd0);
    applyStimulus(OP_MTLO, 32'h0000_CAFE, 32'd0, 1'b0, '0);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("mtlo lo", 64'(bus.lo), 64'h0000_CAFE);
    checkOutput("mtlo hi kept", 64'(bus.hi), 64'hDEAD_BEEF);
    checkOutput("mtlo busy", 64'(bus.busy), 64'd0);
    checkOutput("mtlo done", 64'(bus.done), 64'd0);

    // Asynchronous reset in the middle of CALC.
    done_before = done_count;
    applyStimulus(OP_MULT, 32'd5, 32'd5, 1'b0, '0);
    repeat (6) begin @(negedge clk); bus.start = 1'b0; end
    rst_n = 1'b0;
    #1;
    checkOutput("rst busy", 64'(bus.busy), 64'd0);
    checkOutput("rst hi", 64'(bus.hi), 64'd0);
    checkOutput("rst lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("rst no done", 64'(done_count - done_before), 64'd0);
    checkOutput("rst hi after", 64'(bus.hi), 64'd0);

    // Second MULT and an MTHI while busy must both be ignored.
    done_before = done_count;
    applyStimulus(OP_MULT, 32'd6, 32'd7, 1'b1, {32'd0, 32'd42});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(OP_MULT, 32'd3, 32'd3, 1'b0, '0);
    @(negedge clk);
    applyStimulus(OP_MTHI, 32'h0000_5555, 32'd0, 1'b0, '0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (45) @(negedge clk);
    checkOutput("busy single done", 64'(done_count - done_before), 64'd1);
    checkOutput("busy mthi ignored", 64'(bus.hi), 64'd0);
    checkOutput("busy lo", 64'(bus.lo), 64'd42);

    // flush together with start in IDLE suppresses the start.
    hold_hi = bus.hi;
    bus.flush = 1'b1;
    applyStimulus(OP_MTHI, 32'h0000_1111, 32'd0, 1'b0, '0);
    @(negedge clk);
    applyStimulus(OP_MULT, 32'd9, 32'd9, 1'b0, '0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checkOutput("idle flush hi", 64'(bus.hi), 64'(hold_hi));
    checkOutput("idle flush busy", 64'(bus.busy), 64'd0);

    // flush in the 10th CALC cycle, then flush during FIX.
    for (int pass = 0; pass < 2; pass++) begin
      hold_hi     = bus.hi;
      hold_lo     = bus.lo;
      done_before = done_count;
      applyStimulus(OP_DIVU, 32'd1000, 32'd3, 1'b0, '0);
      for (int c = 1; c <= ((pass == 0) ? 10 : 33); c++) begin
        @(negedge clk);
        if (c == 1) bus.start = 1'b0;
      end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checkOutput($sformatf("flush%0d busy", pass), 64'(bus.busy), 64'd0);
      repeat (40) @(negedge clk);
      checkOutput($sformatf("flush%0d no done", pass), 64'(done_count - done_before), 64'd0);
      checkOutput($sformatf("flush%0d hi", pass), 64'(bus.hi), 64'(hold_hi));
      checkOutput($sformatf("flush%0d lo", pass), 64'(bus.lo), 64'(hold_lo));
    end

    checkOutput("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the ALU and fed by the same ID/EX operand buses. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results are held in HI/LO for later MFHI/MFLO, which the writeback mux reads directly. While an operation is in flight, `busy` stalls the pipeline front end.

## Interface
- `WIDTH`, 32, operand and HI/LO width; `CNT_W` is derived as $clog2(WIDTH)+1
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  issue the operation on `op` this cycle
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops
- `a`  in  32  rs operand, same bus as the ALU `a`
- `b`  in  32  rt operand, same bus as the ALU `b`
- `flush`  in  1  abort any in-flight operation
- `busy`  out  1  operation in flight; decoded combinationally from state != IDLE
- `done`  out  1  registered one-cycle pulse; HI/LO hold the new result during that cycle
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States:
  - IDLE: waiting for an operation.
  - CALC: one iteration per cycle for WIDTH cycles.
  - FIX: applies signs, writes HI/LO, sets `done`, returns to IDLE.
- IDLE with `start`:
  - MULT/MULTU/DIV/DIVU: latch |a|, |b| (magnitudes only for signed ops), neg_q = a[31]^b[31] and neg_r = a[31] (signed ops only), the raw `a`, and div_by_zero = (b==0). Clear the counter and go to CALC.
  - MTHI: hi <= a, stay in IDLE, no `done`.
  - MTLO: lo <= a, stay in IDLE, no `done`.
  - op 110/111: ignored.
- CALC, multiply: shift-add; 64-bit product accumulator {P_hi, P_lo}. Each cycle, if P_lo[0] then P_hi is added to the multiplicand with a 33-bit sum, then the accumulator shifts right by 1.
- CALC, divide: restoring division. Remainder register is 33 bits. Each cycle:
  - shift {rem, quo} left by 1;
  - trial-subtract the divisor;
  - on a non-negative result keep it and set quo[0]=1.
- After WIDTH iterations, CALC goes to FIX.
- FIX, multiply: {hi,lo} <= neg_q ? -product : product. Negation is 64-bit two's complement.
- FIX, divide:
  - lo <= neg_q ? -quo : quo;
  - hi <= neg_r ? -rem : rem.
- Division by zero, either signedness: lo <= 32'hFFFF_FFFF, hi <= raw `a`. Latency is unchanged.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0. This falls out of the magnitude arithmetic and needs no special case.
- `start` while `busy` is ignored, including MTHI/MTLO. The pipeline must hold the instruction until `busy` drops.
- `flush`:
  - In CALC or FIX: return to IDLE on the next edge. HI/LO are unchanged and no `done` is produced.
  - Priority: `flush` beats FIX writeback.
  - In IDLE, `flush` together with `start` suppresses the `start`.

## Timing
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, operand registers 0.
- An asynchronous reset mid-operation discards the operation immediately.
- Operation accepted at edge E0:
  - busy=1 from after E0;
  - CALC occupies edges E1..E32;
  - FIX writeback occurs at edge E33;
  - done=1 and busy=0 during the cycle after E33.
- Total: result readable 33 edges after issue. The next `start` can be accepted at the edge that ends the `done` cycle.
- MTHI/MTLO: the write is visible one edge after issue.
- `hi`/`lo` are registered outputs; they change only at FIX writeback, MTHI/MTLO, or reset.

## Structure
- Shared package `muldiv_pkg`:
  - op code localparams (OP_MULT..OP_MTLO);
  - state enum {IDLE, CALC, FIX};
  - WIDTH default.
- One natural sub-module, `muldiv_addsub`: a 33-bit add/subtract shared by the multiply accumulate and the divide trial subtract. It is selected by a sub input and provides a carry/borrow out.
- The FSM, counter, HI/LO registers and sign fix stay in `muldiv_unit`.

## Test plan
- MULT a=0xFFFF_FFFD (-3), b=5 -> after 33 edges done=1, hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
- MULTU a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001; DIVU 100/7 -> lo=14, hi=2.
- DIV a=-7, b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- DIV a=0x1234, b=0 -> lo=0xFFFF_FFFF, hi=0x1234, same latency, done pulses once.
- MTHI 0xDEAD_BEEF then MTLO 0xCAFE on consecutive cycles -> hi/lo updated one edge after each, busy stays 0. A second MULT issued during busy is ignored: only the first result is written and a single `done` pulse is produced.
- Cases that leave HI/LO unchanged with no `done`:
  - `flush` at the 10th CALC cycle;
  - `rst_n` low mid-CALC, which additionally clears state, busy, hi and lo to 0 immediately.
